// File: rtl/mc_ctrl.sv
// Multicycle main controller for the MIPS-subset CPU: sequences fetch/decode/execute/memory/writeback.
// Optional build macro MC_CTRL_ILLEGAL_HALT_EN: an illegal instruction parks the FSM in HALT until reset.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        PCWr,
    output logic [2:0]  NpcSel,
    output logic        IRWr,
    output logic        RegWr,
    output logic [1:0]  RegDst,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ExtOp,
    output logic        MemWr,
    output logic [1:0]  MemToReg,
    output logic        insn_done,
    output logic        illegal
);

    // state   | meaning
    // FETCH   | load IR, PC <= pc+4
    // DECODE  | dispatch on opcode/funct
    // MEMADR  | compute rs + sext(imm)
    // MEMRD   | data memory read (lw)
    // MEMWB   | write loaded word to rt
    // MEMWR   | data memory write (sw)
    // REXE    | R-type addu/subu execute
    // RWB     | write ALU result to rd
    // IEXE    | ori/lui execute
    // IWB     | write ALU result to rt
    // BRANCH  | beq compare, PC <= target if zero
    // JUMP    | j/jal, jal also links to $31
    // JR      | PC <= rs
    // HALT    | illegal instruction trap (macro builds only)
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_REXE,
        S_RWB,
        S_IEXE,
        S_IWB,
        S_BRANCH,
        S_JUMP,
        S_JR
`ifdef MC_CTRL_ILLEGAL_HALT_EN
        ,
        S_HALT
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state, state_nxt;

    logic [5:0] op;
    logic [5:0] fn;
    logic       is_lw, is_sw, is_addu, is_subu, is_jr;
    logic       is_ori, is_lui, is_beq, is_j, is_jal;
    logic       is_legal;
    logic       unused_instr_bits;

    assign op = instr[31:26];
    assign fn = instr[5:0];

    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_addu = (op == OP_RTYPE) && (fn == FN_ADDU);
    assign is_subu = (op == OP_RTYPE) && (fn == FN_SUBU);
    assign is_jr   = (op == OP_RTYPE) && (fn == FN_JR);
    assign is_ori  = (op == OP_ORI);
    assign is_lui  = (op == OP_LUI);
    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    assign is_jal  = (op == OP_JAL);

    assign is_legal = is_lw | is_sw | is_addu | is_subu | is_jr |
                      is_ori | is_lui | is_beq | is_j | is_jal;

    // Register fields are consumed by the datapath, not by the controller.
    assign unused_instr_bits = ^instr[25:6];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        PCWr      = 1'b0;
        NpcSel    = 3'b000;
        IRWr      = 1'b0;
        RegWr     = 1'b0;
        RegDst    = 2'b00;
        ALUSrc    = 1'b0;
        ALUOp     = 2'b00;
        ExtOp     = 2'b00;
        MemWr     = 1'b0;
        MemToReg  = 2'b00;
        insn_done = 1'b0;
        illegal   = 1'b0;

        case (state)
            S_FETCH: begin
                IRWr      = 1'b1;
                PCWr      = 1'b1;
                NpcSel    = 3'b000;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_lw || is_sw) begin
                    state_nxt = S_MEMADR;
                end else if (is_addu || is_subu) begin
                    state_nxt = S_REXE;
                end else if (is_jr) begin
                    state_nxt = S_JR;
                end else if (is_ori || is_lui) begin
                    state_nxt = S_IEXE;
                end else if (is_beq) begin
                    state_nxt = S_BRANCH;
                end else if (is_j || is_jal) begin
                    state_nxt = S_JUMP;
                end else begin
                    illegal = 1'b1;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
                    state_nxt = S_HALT;
`else
                    state_nxt = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                ALUSrc    = 1'b1;
                ExtOp     = 2'b01;
                ALUOp     = 2'b00;
                state_nxt = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ALUSrc    = 1'b1;
                ExtOp     = 2'b01;
                ALUOp     = 2'b00;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ALUSrc    = 1'b1;
                ExtOp     = 2'b01;
                ALUOp     = 2'b00;
                RegWr     = 1'b1;
                RegDst    = 2'b00;
                MemToReg  = 2'b01;
                insn_done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                ALUSrc    = 1'b1;
                ExtOp     = 2'b01;
                ALUOp     = 2'b00;
                MemWr     = 1'b1;
                insn_done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_REXE: begin
                ALUSrc    = 1'b0;
                ALUOp     = is_subu ? 2'b01 : 2'b00;
                state_nxt = S_RWB;
            end
            S_RWB: begin
                // ALU controls held so the result stays valid without an ALUOut register.
                ALUSrc    = 1'b0;
                ALUOp     = is_subu ? 2'b01 : 2'b00;
                RegWr     = 1'b1;
                RegDst    = 2'b01;
                MemToReg  = 2'b00;
                insn_done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_IEXE: begin
                ALUSrc    = 1'b1;
                ALUOp     = 2'b10;
                ExtOp     = is_lui ? 2'b10 : 2'b00;
                state_nxt = S_IWB;
            end
            S_IWB: begin
                ALUSrc    = 1'b1;
                ALUOp     = 2'b10;
                ExtOp     = is_lui ? 2'b10 : 2'b00;
                RegWr     = 1'b1;
                RegDst    = 2'b00;
                MemToReg  = 2'b00;
                insn_done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrc    = 1'b0;
                ALUOp     = 2'b01;
                NpcSel    = 3'b001;
                PCWr      = zero;
                insn_done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                PCWr      = 1'b1;
                NpcSel    = 3'b010;
                insn_done = 1'b1;
                if (is_jal) begin
                    RegWr    = 1'b1;
                    RegDst   = 2'b10;
                    MemToReg = 2'b10;
                end
                state_nxt = S_FETCH;
            end
            S_JR: begin
                // rs | $0 passes rs through the ALU to the PC mux.
                ALUSrc    = 1'b0;
                ALUOp     = 2'b10;
                PCWr      = 1'b1;
                NpcSel    = 3'b011;
                insn_done = 1'b1;
                state_nxt = S_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_HALT_EN
            S_HALT: begin
                illegal   = 1'b1;
                state_nxt = S_HALT;
            end
`endif
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        // No PC, IR, register or memory write may leak out while in reset.
        if (rst) begin
            PCWr      = 1'b0;
            NpcSel    = 3'b000;
            IRWr      = 1'b0;
            RegWr     = 1'b0;
            RegDst    = 2'b00;
            ALUSrc    = 1'b0;
            ALUOp     = 2'b00;
            ExtOp     = 2'b00;
            MemWr     = 1'b0;
            MemToReg  = 2'b00;
            insn_done = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule
